// File: rtl/tx_seq_pkg.sv
// Shared types, byte constants and the byte-select helper for the UART TX digit sequencer.

package tx_seq_pkg;

   typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} tx_seq_state_t;

   localparam logic [7:0] SEP_COMMA = 8'h2C;
   localparam logic [7:0] EOL_CR    = 8'h0D;
   localparam logic [7:0] EOL_LF    = 8'h0A;

   // Widest snapshot byte_sel can address; callers zero-extend their snapshot to this width.
   localparam int MAX_SNAP_BITS = 2048;
   localparam int SNAP_IDX_W    = $clog2(MAX_SNAP_BITS);

   function automatic logic [7:0] byte_sel(
      input logic [MAX_SNAP_BITS-1:0] snapshot,
      input int                       v,
      input int                       d,
      input int                       n_digits,
      input logic                     phase,
      input logic [7:0]               trailer
   );
      logic [SNAP_IDX_W-1:0] idx;
      logic [7:0]            b;
      idx = SNAP_IDX_W'((v * n_digits + d) * 8);
      if (phase)
         b = trailer;
      else
         b = snapshot[idx +: 8];
      return b;
   endfunction

endpackage

// File: rtl/tx_digit_sequencer.sv
// Streams a snapshot of N_VALUES x N_DIGITS ASCII digits to a UART TX, one TRANS per byte,
// with optional separator / end-of-line bytes, abort, and busy/done status.

module tx_digit_sequencer #(
   parameter int         N_VALUES  = 8,
   parameter int         N_DIGITS  = 3,
   parameter int         MSD_FIRST = 0,
   parameter int         SEP_EN    = 0,
   parameter logic [7:0] SEP_CHAR  = 8'h2C,
   parameter int         EOL_EN    = 0,
   parameter logic [7:0] EOL_CHAR  = 8'h0D
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           START,
   input  logic                           ABORT,
   input  logic [N_VALUES*N_DIGITS*8-1:0] DIGITS,
   input  logic                           TX_DONE,
   output logic [7:0]                     DATATX,
   output logic                           TRANS,
   output logic                           COUNT,
   output logic                           BUSY,
   output logic                           DONE
);

   // Imported after the ports so the DONE port wins; the DONE state is referenced with its package prefix.
   import tx_seq_pkg::*;

   localparam int SNAP_W = N_VALUES * N_DIGITS * 8;
   localparam int DW     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int VW     = (N_VALUES > 1) ? $clog2(N_VALUES) : 1;
   localparam logic [DW-1:0] LAST_D = DW'(N_DIGITS - 1);
   localparam logic [VW-1:0] LAST_V = VW'(N_VALUES - 1);

   tx_seq_state_t   state;
   logic [SNAP_W-1:0] snapshot;
   logic [DW-1:0]   d_idx;
   logic [VW-1:0]   v_idx;
   logic            phase;

   logic [DW-1:0]   digit_pos;
   logic            last_digit;
   logic            last_value;
   logic [7:0]      trailer;
   logic [7:0]      cur_byte;

   // d_idx counts bytes sent within a value; digit_pos maps it onto the digit actually sent.
   assign digit_pos  = (MSD_FIRST != 0) ? (LAST_D - d_idx) : d_idx;
   assign last_digit = (d_idx == LAST_D);
   assign last_value = (v_idx == LAST_V);
   assign trailer    = last_value ? EOL_CHAR : SEP_CHAR;
   assign cur_byte   = byte_sel(MAX_SNAP_BITS'(snapshot), int'(v_idx), int'(digit_pos),
                                N_DIGITS, phase, trailer);

   // State and index sequencing; the trailer slot (phase=1) follows the last digit of a value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         snapshot <= '0;
         d_idx    <= '0;
         v_idx    <= '0;
         phase    <= 1'b0;
      end else if (ABORT) begin
         state <= IDLE;
         d_idx <= '0;
         v_idx <= '0;
         phase <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  state    <= SEND;
                  snapshot <= DIGITS;
                  d_idx    <= '0;
                  v_idx    <= '0;
                  phase    <= 1'b0;
               end
            end
            SEND: state <= WAIT;
            WAIT: begin
               if (TX_DONE) begin
                  if (!phase && !last_digit) begin
                     d_idx <= d_idx + 1'b1;
                     state <= SEND;
                  end else if (!phase && !last_value && (SEP_EN != 0)) begin
                     phase <= 1'b1;
                     state <= SEND;
                  end else if (!phase && last_value && (EOL_EN != 0)) begin
                     phase <= 1'b1;
                     state <= SEND;
                  end else if (!last_value) begin
                     phase <= 1'b0;
                     d_idx <= '0;
                     v_idx <= v_idx + 1'b1;
                     state <= SEND;
                  end else begin
                     phase <= 1'b0;
                     d_idx <= '0;
                     v_idx <= '0;
                     state <= tx_seq_pkg::DONE;
                  end
               end
            end
            tx_seq_pkg::DONE: state <= IDLE;
            default:          state <= IDLE;
         endcase
      end
   end

   // Moore output decode from the registered state.
   always_comb begin
      DATATX = 8'h00;
      TRANS  = 1'b0;
      COUNT  = 1'b0;
      BUSY   = 1'b0;
      DONE   = 1'b0;
      case (state)
         SEND: begin
            TRANS  = 1'b1;
            BUSY   = 1'b1;
            DATATX = cur_byte;
         end
         WAIT: begin
            COUNT  = 1'b1;
            BUSY   = 1'b1;
            DATATX = cur_byte;
         end
         tx_seq_pkg::DONE: begin
            DONE = 1'b1;
            BUSY = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
